ahb_slave_pipe: RTL

AHB-Lite slave front end sitting directly upstream of the AHB-to-APB bridge state machine. Qualifies AHB transfers into a single-cycle `VALID` strobe. Pipelines address, write data and direction into the two-stage registers the bridge consumes. Decodes the 4-slot APB memory map into a one-hot select, and owns `HREADYOUT`/`HRESP` toward the master, including the two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_apb_pkg.sv | 22 ++
 rtl/ahb_addr_decode.sv | 38 +++
 rtl/ahb_slave_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge definitions.
// Transfer encodings, response codes, memory map defaults, error states.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] ADDR_BASE_DEF = 32'h8000_0000;
    localparam int          SLOT_BITS_DEF = 26;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_ERR1 = 2'd1,
        E_ERR2 = 2'd2
    } err_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// APB window decoder.
// Flags legal transfers and yields a one-hot slot select.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
    parameter int          SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic        legal,
    output logic [3:0]  slot_oh
);

    logic in_win;
    logic size_ok;
    logic align_ok;
    logic unused_addr;

    assign unused_addr = ^haddr[SLOT_BITS-1:2];

    assign in_win  = haddr[31:SLOT_BITS+2] == ADDR_BASE[31:SLOT_BITS+2];
    assign size_ok = hsize <= 3'b010;

    // Alignment depends on transfer size; oversize is caught by size_ok.
    always_comb begin
        align_ok = 1'b1;
        unique case (hsize)
            3'b001:  align_ok = ~haddr[0];
            3'b010:  align_ok = haddr[1:0] == 2'b00;
            default: align_ok = 1'b1;
        endcase
    end

    assign legal   = in_win && size_ok && align_ok;
    assign slot_oh = 4'b0001 << haddr[SLOT_BITS+1:SLOT_BITS];

endmodule

// File: rtl/ahb_slave_pipe.sv
// AHB-Lite slave front end for the AHB-to-APB bridge.
// Qualifies transfers, pipelines address/data, owns ERROR response.
module ahb_slave_pipe
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
    parameter int          SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HREADYIN,
    input  logic        BRIDGE_HREADY,
    output logic        VALID,
    output logic        HWRITEREG,
    output logic [31:0] PIPELINE_HADDR_TEMP,
    output logic [31:0] PIPELINE_HADDR,
    output logic [31:0] PIPELINE_HWDATA,
    output logic [3:0]  HSEL,
    output logic        HREADYOUT,
    output logic        HRESP
);

    logic       act;
    logic       legal;
    logic [3:0] slot_oh;
    logic       unused_trans;
    err_state_e err_state;

    assign unused_trans = HTRANS[0];

    ahb_addr_decode #(
        .ADDR_BASE (ADDR_BASE),
        .SLOT_BITS (SLOT_BITS)
    ) u_decode (
        .haddr   (HADDR),
        .hsize   (HSIZE),
        .legal   (legal),
        .slot_oh (slot_oh)
    );

    assign act   = HREADYIN && HTRANS[1];
    assign VALID = act && legal && (err_state == E_IDLE);

    // Address/control pipeline advances only while the bus is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HSEL                <= 4'b0000;
            PIPELINE_HADDR_TEMP <= 32'h0;
            PIPELINE_HADDR      <= 32'h0;
            PIPELINE_HWDATA     <= 32'h0;
            HWRITEREG           <= 1'b0;
        end else if (HREADYIN) begin
            HSEL                <= VALID ? slot_oh : 4'b0000;
            PIPELINE_HADDR_TEMP <= HADDR;
            PIPELINE_HADDR      <= PIPELINE_HADDR_TEMP;
            PIPELINE_HWDATA     <= HWDATA;
            HWRITEREG           <= HWRITE;
        end
    end

    // Two-cycle ERROR sequencer; ERR2 may chain into a new error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_state <= E_IDLE;
        end else begin
            unique case (err_state)
                E_IDLE:  err_state <= (act && !legal) ? E_ERR1 : E_IDLE;
                E_ERR1:  err_state <= E_ERR2;
                E_ERR2:  err_state <= (act && !legal) ? E_ERR1 : E_IDLE;
                default: err_state <= E_IDLE;
            endcase
        end
    end

    // Response toward the master follows the error state.
    always_comb begin
        HREADYOUT = BRIDGE_HREADY;
        HRESP     = HRESP_OKAY;
        unique case (err_state)
            E_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            E_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                HREADYOUT = BRIDGE_HREADY;
                HRESP     = HRESP_OKAY;
            end
        endcase
    end

endmodule
